io_bus_arbiter: RTL and testbench

- Shares a single external memory-mapped IO bus between the IO request queues of NUM_CORES cores.
- Grants one queued non-cacheable request at a time, round-robin across cores.
- Forwards the request to the bus, waits for the response or a timeout, then broadcasts the response back to all cores, tagged with core and thread.
- Sits between the per-core IO request queues and the IO bus bridge; one transaction is outstanding at a time.

---
 rtl/io_bus_arbiter_pkg.sv | 43 ++++
 rtl/io_arb_rr_select.sv | 58 +++++
 rtl/io_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_io_bus_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the IO bus arbiter.
//   - io_arb_state_t : arbiter FSM states
//   - ioreq_packet_t : request packet {is_store, address, value, thread_idx}
//   - iorsp_packet_t : response packet {core, thread_idx, read_value}
//   - IO_TIMEOUT_DATA: read value returned when the bus never answers
//   - idx_width()    : index width helper that never returns 0
// The packet typedefs are sized for the default configuration. The top
// module keeps its own parameterised widths for its ports.
package io_bus_arbiter_pkg;

  localparam int DEFAULT_NUM_CORES        = 4;
  localparam int DEFAULT_THREAD_IDX_WIDTH = 2;
  localparam int CORE_IDX_WIDTH =
    (DEFAULT_NUM_CORES > 1) ? $clog2(DEFAULT_NUM_CORES) : 1;

  localparam logic [31:0] IO_TIMEOUT_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } io_arb_state_t;

  typedef struct packed {
    logic                                is_store;
    logic [31:0]                         address;
    logic [31:0]                         value;
    logic [DEFAULT_THREAD_IDX_WIDTH-1:0] thread_idx;
  } ioreq_packet_t;

  typedef struct packed {
    logic [CORE_IDX_WIDTH-1:0]           core;
    logic [DEFAULT_THREAD_IDX_WIDTH-1:0] thread_idx;
    logic [31:0]                         read_value;
  } iorsp_packet_t;

  // A single core or a zero timeout still needs a 1-bit register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_arb_rr_select.sv
// Round-robin requester select for the IO bus arbiter.
// Picks the first requester at or after the pointer and returns it both
// one-hot and as an index. The pointer moves to grant+1 (mod NUM_CORES)
// on every cycle a grant is actually issued.
// Ports:
//   clk, reset   : clock, synchronous active-low reset (pointer -> core 0)
//   enable       : arbiter is able to accept a request this cycle
//   req          : per-core request valid
//   grant        : one-hot grant, all zero when disabled or nothing requested
//   grant_idx    : index of the granted core
//   grant_valid  : a grant is issued this cycle
module io_arb_rr_select #(
  parameter int NUM_CORES = 4,
  parameter int CW        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_CORES-1:0] req,
  output logic [NUM_CORES-1:0] grant,
  output logic [CW-1:0]        grant_idx,
  output logic                 grant_valid
);

  logic [CW-1:0] ptr;

  // Scan from the farthest candidate back to the pointer so that the last
  // hit written is the closest requester at or after the pointer.
  always_comb begin
    int            sum;
    logic [CW-1:0] idx;
    sum         = 0;
    idx         = '0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_CORES) sum = sum - NUM_CORES;
      idx = CW'(sum);
      if (enable && req[idx]) begin
        grant            = '0;
        grant[idx]       = 1'b1;
        grant_idx        = idx;
        grant_valid      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == CW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// IO bus arbiter: shares one memory-mapped IO bus between the IO request
// queues of NUM_CORES cores, one transaction outstanding at a time.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   ior_request_valid   : per-core request pending
//   ior_request         : per-core {is_store, address, value, thread_idx}
//   ii_ready            : one-hot grant, packet of that core accepted now
//   ii_response_valid   : one-cycle response broadcast
//   ii_response         : {core, thread_idx, read_value}
//   io_req_*            : request to the IO bus bridge
//   io_rsp_valid/_data  : response/ack from the IO bus bridge
//   timeout_event       : pulses with a response synthesised by the timeout
//   dbg_state           : current FSM state (io_arb_state_t encoding)
//
// Handshakes: a request transfers on any cycle where its valid and the
// matching ready are both high. ior_request_valid/ior_request must hold
// until ii_ready; io_req_valid and io_req_* hold stable until io_req_ready.
// io_rsp_valid is a one-cycle strobe only honoured in WAIT.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int NUM_CORES        = 4,
  parameter int THREAD_IDX_WIDTH = 2,
  parameter int TIMEOUT_CYCLES   = 1024,
  localparam int CW = idx_width(NUM_CORES),
  localparam int PW = 1 + 32 + 32 + THREAD_IDX_WIDTH,
  localparam int RW = CW + THREAD_IDX_WIDTH + 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    ior_request_valid,
  input  logic [NUM_CORES*PW-1:0] ior_request,
  output logic [NUM_CORES-1:0]    ii_ready,
  output logic                    ii_response_valid,
  output logic [RW-1:0]           ii_response,
  output logic                    io_req_valid,
  input  logic                    io_req_ready,
  output logic                    io_req_is_store,
  output logic [31:0]             io_req_address,
  output logic [31:0]             io_req_write_data,
  input  logic                    io_rsp_valid,
  input  logic [31:0]             io_rsp_read_data,
  output logic                    timeout_event,
  output logic [1:0]              dbg_state
);

  localparam int TW = idx_width(TIMEOUT_CYCLES + 1);

  io_arb_state_t               state;
  logic [TW-1:0]               cnt;
  logic                        lat_is_store;
  logic [31:0]                 lat_address;
  logic [31:0]                 lat_value;
  logic [THREAD_IDX_WIDTH-1:0] lat_thread;
  logic [CW-1:0]               lat_core;
  logic [31:0]                 rsp_data;

  logic [PW-1:0]               pkts [NUM_CORES];
  logic [PW-1:0]               sel_pkt;
  logic [CW-1:0]               grant_idx;
  logic                        grant_valid;
  logic                        accept_en;

  // Grants are only offered in IDLE and never while reset is asserted,
  // so ii_ready reads zero during reset.
  assign accept_en = reset && (state == IDLE);

  io_arb_rr_select #(
    .NUM_CORES (NUM_CORES),
    .CW        (CW)
  ) u_rr (
    .clk         (clk),
    .reset       (reset),
    .enable      (accept_en),
    .req         (ior_request_valid),
    .grant       (ii_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      pkts[i] = ior_request[i*PW +: PW];
    end
  end

  assign sel_pkt = pkts[grant_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      cnt               <= '0;
      lat_is_store      <= 1'b0;
      lat_address       <= '0;
      lat_value         <= '0;
      lat_thread        <= '0;
      lat_core          <= '0;
      rsp_data          <= '0;
      io_req_valid      <= 1'b0;
      ii_response_valid <= 1'b0;
      timeout_event     <= 1'b0;
    end else begin
      ii_response_valid <= 1'b0;
      timeout_event     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            lat_is_store <= sel_pkt[PW-1];
            lat_address  <= sel_pkt[PW-2 -: 32];
            lat_value    <= sel_pkt[THREAD_IDX_WIDTH+31 -: 32];
            lat_thread   <= sel_pkt[THREAD_IDX_WIDTH-1:0];
            lat_core     <= grant_idx;
            io_req_valid <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (io_req_ready) begin
            io_req_valid <= 1'b0;
            cnt          <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // A response on the expiry cycle wins over the timeout.
          if (io_rsp_valid) begin
            rsp_data          <= lat_is_store ? 32'd0 : io_rsp_read_data;
            ii_response_valid <= 1'b1;
            state             <= RESPOND;
          end else if (TIMEOUT_CYCLES != 0 &&
                       cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_data          <= IO_TIMEOUT_DATA;
            ii_response_valid <= 1'b1;
            timeout_event     <= 1'b1;
            state             <= RESPOND;
          end else if (cnt != '1) begin
            // Saturates when the timeout is disabled instead of wrapping.
            cnt <= cnt + 1'b1;
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_req_is_store   = lat_is_store;
  assign io_req_address    = lat_address;
  assign io_req_write_data = lat_value;
  assign ii_response       = {lat_core, lat_thread, rsp_data};
  assign dbg_state         = state;

endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;
  import io_bus_arbiter_pkg::*;

  localparam int NC  = 4;
  localparam int TIW = 2;
  localparam int TO  = 8;
  localparam int CW  = 2;
  localparam int PW  = 1 + 32 + 32 + TIW;
  localparam int RW  = CW + TIW + 32;
  localparam int W   = RW + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NC-1:0]     ior_request_valid = '0;
  logic [NC*PW-1:0]  ior_request = '0;
  logic [NC-1:0]     ii_ready;
  logic              ii_response_valid;
  logic [RW-1:0]     ii_response;
  logic              io_req_valid;
  logic              io_req_ready = 1'b0;
  logic              io_req_is_store;
  logic [31:0]       io_req_address;
  logic [31:0]       io_req_write_data;
  logic              io_rsp_valid = 1'b0;
  logic [31:0]       io_rsp_read_data = '0;
  logic              timeout_event;
  logic [1:0]        dbg_state;

  logic [W-1:0]      exp_q[$];
  int                total = 0;
  int                bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  io_bus_arbiter #(
    .NUM_CORES        (NC),
    .THREAD_IDX_WIDTH (TIW),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ior_request_valid (ior_request_valid),
    .ior_request       (ior_request),
    .ii_ready          (ii_ready),
    .ii_response_valid (ii_response_valid),
    .ii_response       (ii_response),
    .io_req_valid      (io_req_valid),
    .io_req_ready      (io_req_ready),
    .io_req_is_store   (io_req_is_store),
    .io_req_address    (io_req_address),
    .io_req_write_data (io_req_write_data),
    .io_rsp_valid      (io_rsp_valid),
    .io_rsp_read_data  (io_rsp_read_data),
    .timeout_event     (timeout_event),
    .dbg_state         (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int core, input logic st,
                         input logic [31:0] addr, input logic [31:0] val,
                         input logic [TIW-1:0] th);
    ioreq_packet_t p;
    p.is_store   = st;
    p.address    = addr;
    p.value      = val;
    p.thread_idx = th;
    ior_request[core*PW +: PW] = p;
    ior_request_valid[core]    = 1'b1;
  endtask

  task automatic push_exp(input logic to, input logic [CW-1:0] core,
                          input logic [TIW-1:0] th, input logic [31:0] data);
    iorsp_packet_t r;
    r.core       = core;
    r.thread_idx = th;
    r.read_value = data;
    exp_q.push_back({to, r});
  endtask

  task automatic do_reset();
    ior_request_valid = '0;
    io_req_ready      = 1'b0;
    io_rsp_valid      = 1'b0;
    io_rsp_read_data  = '0;
    reset             = 1'b0;
    cyc();
    at_sample();
    check("rst_ready",     64'(ii_ready),          64'd0);
    check("rst_req_valid", 64'(io_req_valid),      64'd0);
    check("rst_rsp_valid", 64'(ii_response_valid), 64'd0);
    check("rst_rsp",       64'(ii_response),       64'd0);
    check("rst_addr",      64'(io_req_address),    64'd0);
    check("rst_timeout",   64'(timeout_event),     64'd0);
    check("rst_state",     64'(dbg_state),         64'(IDLE));
    cyc();
    reset = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset && ii_response_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(ii_response_valid), 64'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("rsp", 64'({timeout_event, ii_response}), 64'(e));
      end
    end
    if (ii_ready != '0) check("ready_onehot", 64'($countones(ii_ready)), 64'd1);
  end

  // ---------------- stimulus ----------------
  initial begin
    // Single load: grant cycle 0, bus request cycle 1, response cycle 3.
    do_reset();
    set_req(2, 1'b0, 32'h100, 32'h0, 2'd1);
    io_req_ready = 1'b1;
    push_exp(1'b0, 2'd2, 2'd1, 32'hDEADBEEF);
    at_sample();
    check("t1_grant", 64'(ii_ready), 64'(4'b0100));
    cyc();
    ior_request_valid = '0;
    at_sample();
    check("t1_issue_valid", 64'(io_req_valid),    64'd1);
    check("t1_addr",        64'(io_req_address),  64'h100);
    check("t1_store",       64'(io_req_is_store), 64'd0);
    check("t1_ready_off",   64'(ii_ready),        64'd0);
    cyc();
    io_rsp_valid = 1'b1;
    io_rsp_read_data = 32'hDEADBEEF;
    at_sample();
    check("t1_wait_norsp", 64'(ii_response_valid), 64'd0);
    check("t1_wait_reqv",  64'(io_req_valid),      64'd0);
    cyc();
    io_rsp_valid = 1'b0;
    io_rsp_read_data = '0;
    at_sample();
    check("t1_rsp_c3", 64'(ii_response_valid), 64'd1);
    cyc();
    at_sample();
    check("t1_rsp_once", 64'(ii_response_valid), 64'd0);
    check("t1_idle",     64'(dbg_state),         64'(IDLE));

    // Fairness: all cores request continuously, immediate responses.
    do_reset();
    for (int c = 0; c < NC; c++) set_req(c, 1'b0, 32'h400 + c * 4, 32'h0, TIW'(c));
    io_req_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % NC;
      at_sample();
      check("fair_grant", 64'(ii_ready), 64'(1 << g));
      push_exp(1'b0, CW'(g), TIW'(g), 32'h1000 + k);
      cyc();
      at_sample();
      check("fair_addr", 64'(io_req_address), 64'(32'h400 + g * 4));
      cyc();
      io_rsp_valid = 1'b1;
      io_rsp_read_data = 32'h1000 + k;
      cyc();
      io_rsp_valid = 1'b0;
      at_sample();
      check("fair_rsp", 64'(ii_response_valid), 64'd1);
      cyc();
    end
    ior_request_valid = '0;

    // Backpressure on a store; response strobe during ISSUE is ignored.
    do_reset();
    set_req(1, 1'b1, 32'h200, 32'hCAFEF00D, 2'd3);
    io_req_ready = 1'b0;
    push_exp(1'b0, 2'd1, 2'd3, 32'h0);
    at_sample();
    check("bp_grant", 64'(ii_ready), 64'(4'b0010));
    cyc();
    ior_request_valid = '0;
    ior_request = '0;
    for (int i = 0; i < 5; i++) begin
      io_rsp_valid = (i == 2);
      io_rsp_read_data = 32'h1234;
      at_sample();
      check("bp_valid", 64'(io_req_valid),      64'd1);
      check("bp_addr",  64'(io_req_address),    64'h200);
      check("bp_data",  64'(io_req_write_data), 64'hCAFEF00D);
      check("bp_store", 64'(io_req_is_store),   64'd1);
      check("bp_state", 64'(dbg_state),         64'(ISSUE));
      cyc();
    end
    io_rsp_valid = 1'b0;
    io_req_ready = 1'b1;
    at_sample();
    check("bp_still_issue", 64'(io_req_valid), 64'd1);
    cyc();
    io_req_ready = 1'b0;
    io_rsp_valid = 1'b1;
    io_rsp_read_data = 32'h5555_5555;
    at_sample();
    check("bp_wait", 64'(dbg_state), 64'(WAIT));
    cyc();
    io_rsp_valid = 1'b0;
    at_sample();
    check("bp_rsp", 64'(ii_response_valid), 64'd1);
    cyc();

    // Timeout after exactly TO WAIT cycles.
    do_reset();
    io_req_ready = 1'b1;
    set_req(3, 1'b0, 32'h300, 32'h0, 2'd0);
    push_exp(1'b1, 2'd3, 2'd0, 32'hFFFF_FFFF);
    at_sample();
    check("to_grant", 64'(ii_ready), 64'(4'b1000));
    cyc();
    ior_request_valid = '0;
    cyc();
    for (int w = 0; w < TO; w++) begin
      at_sample();
      check("to_wait",  64'(dbg_state),         64'(WAIT));
      check("to_norsp", 64'(ii_response_valid), 64'd0);
      cyc();
    end
    at_sample();
    check("to_rsp",   64'(ii_response_valid), 64'd1);
    check("to_event", 64'(timeout_event),     64'd1);
    cyc();
    at_sample();
    check("to_event_once", 64'(timeout_event), 64'd0);

    // Response on the expiry cycle wins.
    cyc();
    set_req(0, 1'b0, 32'h304, 32'h0, 2'd2);
    push_exp(1'b0, 2'd0, 2'd2, 32'hA5A5_A5A5);
    at_sample();
    check("race_grant", 64'(ii_ready), 64'(4'b0001));
    cyc();
    ior_request_valid = '0;
    cyc();
    for (int w = 0; w < TO; w++) begin
      if (w == TO - 1) begin
        io_rsp_valid = 1'b1;
        io_rsp_read_data = 32'hA5A5_A5A5;
      end
      at_sample();
      check("race_wait", 64'(dbg_state), 64'(WAIT));
      cyc();
    end
    io_rsp_valid = 1'b0;
    at_sample();
    check("race_rsp",   64'(ii_response_valid), 64'd1);
    check("race_event", 64'(timeout_event),     64'd0);
    cyc();

    // Reset in the middle of WAIT abandons the transaction.
    do_reset();
    io_req_ready = 1'b1;
    set_req(1, 1'b0, 32'h500, 32'h0, 2'd1);
    at_sample();
    check("rw_grant", 64'(ii_ready), 64'(4'b0010));
    cyc();
    ior_request_valid = '0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    at_sample();
    check("rw_req_valid", 64'(io_req_valid),      64'd0);
    check("rw_rsp_valid", 64'(ii_response_valid), 64'd0);
    check("rw_rsp",       64'(ii_response),       64'd0);
    check("rw_addr",      64'(io_req_address),    64'd0);
    check("rw_state",     64'(dbg_state),         64'(IDLE));
    cyc();
    io_rsp_valid = 1'b1;
    io_rsp_read_data = 32'h7777;
    cyc();
    io_rsp_valid = 1'b0;
    at_sample();
    check("rw_stale", 64'(ii_response_valid), 64'd0);
    cyc();
    set_req(0, 1'b0, 32'h600, 32'h0, 2'd0);
    set_req(3, 1'b0, 32'h604, 32'h0, 2'd3);
    push_exp(1'b0, 2'd0, 2'd0, 32'h8888);
    at_sample();
    check("rw_ptr0", 64'(ii_ready), 64'(4'b0001));
    cyc();
    ior_request_valid = '0;
    cyc();
    io_rsp_valid = 1'b1;
    io_rsp_read_data = 32'h8888;
    cyc();
    io_rsp_valid = 1'b0;
    at_sample();
    check("rw_rsp_after", 64'(ii_response_valid), 64'd1);
    cyc();
    at_sample();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
